// File: rtl/bpmc_pkg.sv
// Shared definitions for the bit-stream accumulator and its upstream mux stage.
package bpmc_pkg;

  // Controller states, encoded explicitly so debug taps decode the same way everywhere.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default window size (log2) and upstream fill latency. The mux stage uses the
  // same latency value, so both ends of the pipeline agree on it.
  localparam int BPMC_WIN_LOG2 = 8;
  localparam int BPMC_PIPE_LAT = 4;

endpackage

// File: rtl/bpmc_phase_cnt.sv
// Clearable, enabled up-counter with a terminal-value compare. It times both the
// FLUSH phase and the ACC window; the caller picks the terminal value per phase.
module bpmc_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] cnt;

  // Clear has priority over enable, so the phase restarts cleanly on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/bpmc_stream_accum.sv
// Stream-to-binary converter: after Start, it discards PIPE_LAT fill cycles and
// then counts the ones on Bit_in over 2^WIN_LOG2 consecutive cycles.
//
// Handshake: Start is a request level sampled only in IDLE. There is no ready
// signal; Busy high means the request will not be taken. Done is a single-cycle
// valid pulse, and Count is new in that cycle and holds until the next Done.
module bpmc_stream_accum
  import bpmc_pkg::*;
#(
  parameter int WIN_LOG2 = BPMC_WIN_LOG2,
  parameter int PIPE_LAT = BPMC_PIPE_LAT,
  parameter int CNT_W    = WIN_LOG2 + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Bit_in,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Count,
  output state_t           dbg_state
);

  // One counter serves both phases, so it is sized for the larger terminal value.
  localparam int FL_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int PH_W = (WIN_LOG2 > FL_W) ? WIN_LOG2 : FL_W;
  localparam logic [PH_W-1:0] FLUSH_TERM = PH_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [PH_W-1:0] WIN_TERM   = PH_W'((1 << WIN_LOG2) - 1);

  state_t           state;
  state_t           state_nxt;
  logic [PH_W-1:0]  ph_term;
  logic             ph_last;
  logic             ph_clr;
  logic             ph_en;
  logic             acc_clr;
  logic             acc_en;
  logic             cnt_load;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] bit_ext;

  assign bit_ext = {{(CNT_W-1){1'b0}}, Bit_in};
  assign ph_term = (state == FLUSH) ? FLUSH_TERM : WIN_TERM;

  bpmc_phase_cnt #(.W(PH_W)) u_phase (
    .clk     (Clock),
    .rst_n   (Reset),
    .clr     (ph_clr),
    .en      (ph_en),
    .term    (ph_term),
    .at_term (ph_last)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes. Abort is only qualified in FLUSH/ACC and
  // wins over the final ACC edge; the last ACC sample is folded into Count.
  always_comb begin
    state_nxt = state;
    ph_clr    = 1'b0;
    ph_en     = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    cnt_load  = 1'b0;
    case (state)
      IDLE: begin
        ph_clr = 1'b1;
        if (Start) begin
          state_nxt = (PIPE_LAT == 0) ? ACC : FLUSH;
          acc_clr   = 1'b1;
        end
      end
      FLUSH: begin
        if (Abort) begin
          state_nxt = IDLE;
        end else if (ph_last) begin
          state_nxt = ACC;
          ph_clr    = 1'b1;
          acc_clr   = 1'b1;
        end else begin
          ph_en = 1'b1;
        end
      end
      ACC: begin
        if (Abort) begin
          state_nxt = IDLE;
        end else if (ph_last) begin
          state_nxt = DONE;
          cnt_load  = 1'b1;
        end else begin
          ph_en  = 1'b1;
          acc_en = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Running ones count for the current window; cleared on entry to ACC.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + bit_ext;
    end
  end

  // Result register; only a completed window updates it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Count <= '0;
    end else if (cnt_load) begin
      Count <= acc + bit_ext;
    end
  end

  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);
  assign dbg_state = state;

endmodule
